// File: rtl/reg_file_scb.sv
// Register file with a per-register busy scoreboard for multi-cycle loads.
// Optional same-cycle write forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_scb #(
  parameter int DW = 8,
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [DW-1:0] dat_in,
  input  logic          mark_en,
  input  logic [PW-1:0] mark_addr,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic [DW-1:0] dat0_out,
  output logic          busyA,
  output logic          busyB,
  output logic [PW:0]   busy_cnt
);

  localparam int DEPTH = 1 << PW;

  logic [DEPTH-1:0][DW-1:0] core_q, core_d;
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [PW:0]              cnt_q, cnt_d;

  function automatic logic [PW:0] popcount(input logic [DEPTH-1:0] v);
    logic [PW:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{PW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Next state: the write clears busy first so a same-address mark ends up set.
  always_comb begin
    core_d = core_q;
    busy_d = busy_q;
    if (wr_en) begin
      core_d[wr_addr] = dat_in;
      busy_d[wr_addr] = 1'b0;
    end else begin
      core_d = core_q;
    end
    if (mark_en) begin
      busy_d[mark_addr] = 1'b1;
    end else begin
      busy_d[mark_addr] = busy_d[mark_addr];
    end
    cnt_d = popcount(busy_d);
  end

  // State registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_q <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      core_q <= core_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

`ifdef REG_FILE_BYPASS_EN
  logic fwd_ok_s;
  assign fwd_ok_s = rst_n && wr_en;

  // Forwarded read path: an in-flight write is visible in the same cycle.
  always_comb begin
    datA_out = core_q[rd_addrA];
    datB_out = core_q[rd_addrB];
    dat0_out = core_q[0];
    busyA    = busy_q[rd_addrA];
    busyB    = busy_q[rd_addrB];
    if (fwd_ok_s && (rd_addrA == wr_addr)) begin
      datA_out = dat_in;
      busyA    = (mark_en && (mark_addr == wr_addr)) ? busy_q[rd_addrA] : 1'b0;
    end else begin
      datA_out = core_q[rd_addrA];
    end
    if (fwd_ok_s && (rd_addrB == wr_addr)) begin
      datB_out = dat_in;
      busyB    = (mark_en && (mark_addr == wr_addr)) ? busy_q[rd_addrB] : 1'b0;
    end else begin
      datB_out = core_q[rd_addrB];
    end
    if (fwd_ok_s && (wr_addr == {PW{1'b0}})) begin
      dat0_out = dat_in;
    end else begin
      dat0_out = core_q[0];
    end
  end
`else
  // Plain read path: stored state only.
  always_comb begin
    datA_out = core_q[rd_addrA];
    datB_out = core_q[rd_addrB];
    dat0_out = core_q[0];
    busyA    = busy_q[rd_addrA];
    busyB    = busy_q[rd_addrB];
  end
`endif

endmodule

// File: tb/tb_reg_file_scb.sv
// Scoreboard bench for reg_file_scb: a reference model pushes expected outputs,
// which are popped and compared against the DUT each check point.
module tb_reg_file_scb;

  localparam int DW = 8;
  localparam int PW = 3;
  localparam int DEPTH = 1 << PW;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic [DW-1:0] dat_in;
  logic          mark_en;
  logic [PW-1:0] mark_addr;
  logic [PW-1:0] rd_addrA;
  logic [PW-1:0] rd_addrB;
  logic [DW-1:0] datA_out;
  logic [DW-1:0] datB_out;
  logic [DW-1:0] dat0_out;
  logic          busyA;
  logic          busyB;
  logic [PW:0]   busy_cnt;

  logic [DW-1:0]    core_m [DEPTH];
  logic [DEPTH-1:0] busy_m;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          checks;
  int          failures;

  reg_file_scb #(.DW(DW), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .mark_en(mark_en), .mark_addr(mark_addr), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(datA_out), .datB_out(datB_out), .dat0_out(dat0_out),
    .busyA(busyA), .busyB(busyB), .busy_cnt(busy_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    string t;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got 0x%0h expected none", obs);
    end else begin
      t = tag_q.pop_front();
      chk(t, obs, exp_q.pop_front());
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) core_m[i] = '0;
    busy_m = '0;
  endfunction

  // Expected outputs from the model given the current inputs.
  task automatic check_all();
    logic [DW-1:0] ea, eb, e0;
    logic          ba, bb;
    ea = core_m[rd_addrA];
    eb = core_m[rd_addrB];
    e0 = core_m[0];
    ba = busy_m[rd_addrA];
    bb = busy_m[rd_addrB];
`ifdef REG_FILE_BYPASS_EN
    if (rst_n && wr_en) begin
      if (rd_addrA == wr_addr) begin
        ea = dat_in;
        if (!(mark_en && mark_addr == wr_addr)) ba = 1'b0;
      end
      if (rd_addrB == wr_addr) begin
        eb = dat_in;
        if (!(mark_en && mark_addr == wr_addr)) bb = 1'b0;
      end
      if (wr_addr == '0) e0 = dat_in;
    end
`endif
    push_exp("datA", 32'(ea));
    push_exp("datB", 32'(eb));
    push_exp("dat0", 32'(e0));
    push_exp("busyA", 32'(ba));
    push_exp("busyB", 32'(bb));
    push_exp("busy_cnt", 32'($countones(busy_m)));
    pop_cmp(32'(datA_out));
    pop_cmp(32'(datB_out));
    pop_cmp(32'(dat0_out));
    pop_cmp(32'(busyA));
    pop_cmp(32'(busyB));
    pop_cmp(32'(busy_cnt));
  endtask

  // Advance one clock; model mirrors the intended behaviour, mark wins on collision.
  task automatic tick();
    logic          w, m;
    logic [PW-1:0] wa, ma;
    logic [DW-1:0] d;
    w = wr_en; m = mark_en; wa = wr_addr; ma = mark_addr; d = dat_in;
    @(posedge clk);
    if (rst_n) begin
      if (w) begin
        core_m[wa] = d;
        busy_m[wa] = 1'b0;
      end
      if (m) busy_m[ma] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0;
    mark_en = 1'b0;
  endtask

  task automatic do_mark(input int a);
    idle();
    mark_en = 1'b1;
    mark_addr = PW'(a);
    tick();
    idle();
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    idle();
    wr_en = 1'b1;
    wr_addr = PW'(a);
    dat_in = d;
    tick();
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; dat_in = '0;
    mark_en = 1'b0; mark_addr = '0;
    rd_addrA = '0; rd_addrB = '0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();

    // Write/read on shared address.
    do_write(5, 8'hC3);
    rd_addrA = 3'd5; rd_addrB = 3'd5;
    #1;
    chk("wr5_A", 32'(datA_out), 32'h0000_00C3);
    chk("wr5_B", 32'(datB_out), 32'h0000_00C3);
    chk("wr5_dat0", 32'(dat0_out), 32'h0000_0000);
    check_all();

    // Scoreboard mark and clear.
    do_mark(2);
    do_mark(7);
    rd_addrA = 3'd2; rd_addrB = 3'd7;
    #1;
    chk("mark_cnt2", 32'(busy_cnt), 32'd2);
    chk("mark_busyA", 32'(busyA), 32'd1);
    check_all();
    do_write(2, 8'h11);
    #1;
    chk("clr_cnt1", 32'(busy_cnt), 32'd1);
    chk("clr_busyA", 32'(busyA), 32'd0);
    chk("clr_datA", 32'(datA_out), 32'h0000_0011);
    check_all();

    // Collision on r4: data written, mark wins.
    wr_en = 1'b1; wr_addr = 3'd4; dat_in = 8'h99;
    mark_en = 1'b1; mark_addr = 3'd4;
    tick();
    idle();
    rd_addrA = 3'd4;
    #1;
    chk("coll_dat", 32'(datA_out), 32'h0000_0099);
    chk("coll_busy", 32'(busyA), 32'd1);
    chk("coll_cnt", 32'(busy_cnt), 32'd2);
    check_all();

    // Write to busy r1 observed within the same cycle.
    do_mark(1);
    wr_en = 1'b1; wr_addr = 3'd1; dat_in = 8'h3C; rd_addrA = 3'd1;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("byp_dat", 32'(datA_out), 32'h0000_003C);
    chk("byp_busy", 32'(busyA), 32'd0);
`else
    chk("nobyp_dat", 32'(datA_out), 32'h0000_0000);
    chk("nobyp_busy", 32'(busyA), 32'd1);
`endif
    check_all();
    tick();
    idle();
    #1;
    chk("r1_after", 32'(datA_out), 32'h0000_003C);
    chk("r1_busy_after", 32'(busyA), 32'd0);

    // Fill the scoreboard; count must reach DEPTH without wrapping.
    for (int i = 0; i < DEPTH; i++) do_mark(i);
    #1;
    chk("full_cnt", 32'(busy_cnt), 32'd8);
    do_mark(0);
    #1;
    chk("remark_cnt", 32'(busy_cnt), 32'd8);
    check_all();

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      wr_en = 1'($urandom_range(1, 0));
      wr_addr = PW'($urandom_range(DEPTH - 1, 0));
      dat_in = DW'($urandom);
      mark_en = 1'($urandom_range(1, 0));
      mark_addr = PW'($urandom_range(DEPTH - 1, 0));
      rd_addrA = PW'($urandom_range(DEPTH - 1, 0));
      rd_addrB = PW'($urandom_range(DEPTH - 1, 0));
      #1;
      check_all();
      tick();
    end
    idle();

    // Asynchronous reset between edges with operations pending.
    do_write(3, 8'h5A);
    do_mark(6);
    rd_addrA = 3'd3;
    #1;
    chk("pre_rst_r3", 32'(datA_out), 32'h0000_005A);
    #2;
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd3; dat_in = 8'hEE;
    mark_en = 1'b1; mark_addr = 3'd3;
    #1;
    model_reset();
    chk("rst_datA", 32'(datA_out), 32'h0000_0000);
    chk("rst_cnt", 32'(busy_cnt), 32'd0);
    check_all();
    tick();
    check_all();
    rst_n = 1'b1;
    tick();
    idle();
    #1;
    chk("post_rst_wr", 32'(datA_out), 32'h0000_00EE);
    chk("post_rst_busy", 32'(busyA), 32'd1);
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
